// File: rtl/instruction_fetch.sv
// instruction_fetch: PC register, in-order imem requests, instruction buffer, redirect flush.
// Optional FETCH_PERF_EN adds a delivered-instruction counter (fetch_count/clear_count).
module instruction_fetch #(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc,
`ifdef FETCH_PERF_EN
  output logic [31:0]       fetch_count,
  input  logic              clear_count,
`endif
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int SW = CW + 2;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]     out_cnt_q, out_cnt_d;
  logic [CW-1:0]     drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]     buf_cnt_q, buf_cnt_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [31:0]       buf_inst_q [DEPTH];
  logic [ADDR_W-1:0] buf_pc_q [DEPTH];
  logic [SW-1:0]     credit_used;
  logic              req_fire;
  logic              rsp_drop;
  logic              rsp_push;
  logic              rsp_live;
  logic              pop;

  assign inst_valid = (buf_cnt_q != '0);
  assign inst       = inst_valid ? buf_inst_q[rd_ptr_q] : '0;
  assign inst_pc    = inst_valid ? buf_pc_q[rd_ptr_q] : '0;
  assign pop        = inst_valid & inst_ready;

  // Credit check, handshake decode, redirect flush and FSM next state.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    rsp_pc_d   = rsp_pc_q;
    out_cnt_d  = out_cnt_q;
    drop_cnt_d = drop_cnt_q;
    buf_cnt_d  = buf_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;

    credit_used = SW'(out_cnt_q) + SW'(drop_cnt_q)
                + SW'(buf_cnt_q);
    imem_req_valid = (state_q != BOOT)
                   && (credit_used < SW'(DEPTH));
    imem_req_addr  = pc_q;
    req_fire = imem_req_valid & imem_req_ready;
    rsp_drop = imem_rsp_valid & (drop_cnt_q != '0);
    rsp_push = imem_rsp_valid & (drop_cnt_q == '0)
             & (out_cnt_q != '0);
    rsp_live = rsp_drop | rsp_push;

    if (redirect_valid) begin
      pc_d       = redirect_pc & ~ADDR_W'(3);
      rsp_pc_d   = redirect_pc & ~ADDR_W'(3);
      drop_cnt_d = drop_cnt_q + out_cnt_q
                 + CW'(req_fire) - CW'(rsp_live);
      out_cnt_d  = '0;
      buf_cnt_d  = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end else begin
      if (req_fire) pc_d = pc_q + ADDR_W'(4);
      if (rsp_push) rsp_pc_d = rsp_pc_q + ADDR_W'(4);
      out_cnt_d  = out_cnt_q + CW'(req_fire)
                 - CW'(rsp_push);
      drop_cnt_d = drop_cnt_q - CW'(rsp_drop);
      buf_cnt_d  = buf_cnt_q + CW'(rsp_push) - CW'(pop);
      wr_ptr_d   = wr_ptr_q + PW'(rsp_push);
      rd_ptr_d   = rd_ptr_q + PW'(pop);
    end

    unique case (state_q)
      BOOT:  state_d = RUN;
      RUN: begin
        if (redirect_valid && drop_cnt_d != '0)
          state_d = FLUSH;
      end
      FLUSH: begin
        if (!redirect_valid && drop_cnt_d == '0)
          state_d = RUN;
      end
      default: state_d = BOOT;
    endcase
  end

  // FSM, PC and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
      buf_cnt_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      rsp_pc_q   <= rsp_pc_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      buf_cnt_q  <= buf_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Buffer storage; a response is written only when kept and not flushed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        buf_inst_q[i] <= '0;
        buf_pc_q[i]   <= '0;
      end
    end else if (rsp_push && !redirect_valid) begin
      buf_inst_q[wr_ptr_q] <= imem_rsp_data;
      buf_pc_q[wr_ptr_q]   <= rsp_pc_q;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count_q;

  // Delivered-instruction counter; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count_q <= '0;
    end else if (clear_count) begin
      fetch_count_q <= '0;
    end else if (pop) begin
      fetch_count_q <= fetch_count_q + 32'd1;
    end
  end

  assign fetch_count = fetch_count_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed checks of instruction_fetch
// against a small latency-programmable memory model.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b1;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count;
  logic        clear_count = 1'b0;
`endif

  instruction_fetch #(
    .ADDR_W(64), .RESET_PC(64'h0), .DEPTH(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .inst(inst),
    .inst_pc(inst_pc),
`ifdef FETCH_PERF_EN
    .fetch_count(fetch_count),
    .clear_count(clear_count),
`endif
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] wd(input logic [63:0] a);
    logic [31:0] lo;
    lo = a[31:0];
    return lo ^ 32'hC0DE_0000;
  endfunction

  // memory model
  int          lat = 1;
  int          cyc = 0;
  logic [63:0] pend_a[$];
  int          pend_due[$];
  logic [63:0] acc_log[$];
  logic [63:0] got_pc[$];
  logic [31:0] got_in[$];

  always @(negedge clk) begin
    cyc = cyc + 1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (!rst_n) begin
      pend_a.delete();
      pend_due.delete();
      acc_log.delete();
    end else begin
      if (pend_a.size() > 0 && pend_due[0] <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = wd(pend_a[0]);
        void'(pend_a.pop_front());
        void'(pend_due.pop_front());
      end
      #1;
      if (rst_n && imem_req_valid && imem_req_ready) begin
        pend_a.push_back(imem_req_addr);
        pend_due.push_back(cyc + lat);
        acc_log.push_back(imem_req_addr);
      end
    end
  end

  // decode-side monitor
  always @(posedge clk) begin
    if (!rst_n) begin
      got_pc.delete();
      got_in.delete();
    end else if (inst_valid && inst_ready) begin
      got_pc.push_back(inst_pc);
      got_in.push_back(inst);
    end
  end

  task automatic do_reset(input int l);
    @(negedge clk);
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    lat = l;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int idx;

    // reset and streaming
    repeat (2) @(negedge clk);
    #2;
    check("rst_req_valid", 64'(imem_req_valid), 64'd0);
    check("rst_inst_valid", 64'(inst_valid), 64'd0);
    check("rst_inst", 64'(inst), 64'd0);
    check("rst_inst_pc", inst_pc, 64'd0);
    rst_n = 1'b1;
    #1;
    check("boot_req_valid", 64'(imem_req_valid), 64'd0);
    @(negedge clk);
    #2;
    check("first_req_valid", 64'(imem_req_valid), 64'd1);
    check("first_req_addr", imem_req_addr, 64'h0);
    repeat (12) @(negedge clk);
    check("t1_count", 64'(got_pc.size() >= 3), 64'd1);
    check("t1_pc0", got_pc[0], 64'h0);
    check("t1_pc1", got_pc[1], 64'h4);
    check("t1_pc2", got_pc[2], 64'h8);
    check("t1_inst1", 64'(got_in[1]), 64'(wd(64'h4)));

    // backpressure: credits stop requests at DEPTH
    inst_ready = 1'b0;
    do_reset(1);
    repeat (8) @(negedge clk);
    #2;
    check("bp_accepts", 64'(acc_log.size()), 64'd2);
    check("bp_acc0", acc_log[0], 64'h0);
    check("bp_acc1", acc_log[1], 64'h4);
    check("bp_req_valid", 64'(imem_req_valid), 64'd0);
    check("bp_inst_valid", 64'(inst_valid), 64'd1);
    check("bp_inst", 64'(inst), 64'(wd(64'h0)));
    check("bp_inst_pc", inst_pc, 64'h0);
    inst_ready = 1'b1;
    repeat (10) @(negedge clk);
    check("bp_pc0", got_pc[0], 64'h0);
    check("bp_pc1", got_pc[1], 64'h4);
    check("bp_pc2", got_pc[2], 64'h8);

    // redirect with two slow responses outstanding
    inst_ready = 1'b0;
    do_reset(3);
    repeat (3) @(negedge clk);
    check("fl_outstanding", 64'(acc_log.size()), 64'd2);
    redirect_valid = 1'b1;
    redirect_pc = 64'h100;
    @(negedge clk);
    redirect_valid = 1'b0;
    inst_ready = 1'b1;
    #2;
    check("fl_drop", 64'(dut.drop_cnt_q), 64'd2);
    check("fl_state_flush", 64'(dut.state_q), 64'd2);
    repeat (12) @(negedge clk);
    #2;
    check("fl_state_run", 64'(dut.state_q), 64'd1);
    check("fl_pc0", got_pc[0], 64'h100);
    check("fl_inst0", 64'(got_in[0]), 64'(wd(64'h100)));
    check("fl_pc1", got_pc[1], 64'h104);

    // redirect coinciding with response and request
    inst_ready = 1'b1;
    do_reset(1);
    repeat (2) @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 64'h200;
    @(negedge clk);
    redirect_valid = 1'b0;
    #2;
    check("co_drop", 64'(dut.drop_cnt_q), 64'd1);
    check("co_state", 64'(dut.state_q), 64'd2);
    repeat (10) @(negedge clk);
    check("co_count", 64'(got_pc.size() >= 2), 64'd1);
    check("co_pc0", got_pc[0], 64'h200);
    check("co_inst0", 64'(got_in[0]), 64'(wd(64'h200)));
    check("co_pc1", got_pc[1], 64'h204);

    // PC wrap and unaligned redirect target
    do_reset(1);
    repeat (4) @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    @(negedge clk);
    redirect_valid = 1'b0;
    repeat (8) @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 64'h103;
    @(negedge clk);
    redirect_valid = 1'b0;
    repeat (10) @(negedge clk);
    #2;
    idx = -1;
    for (int i = 0; i < acc_log.size(); i++)
      if (idx < 0 && acc_log[i] == 64'hFFFF_FFFF_FFFF_FFFC)
        idx = i;
    check("wr_found", 64'(idx >= 0), 64'd1);
    check("wr_next_addr", acc_log[idx+1], 64'h0);
    idx = -1;
    for (int i = 0; i < got_pc.size(); i++)
      if (idx < 0 && got_pc[i] == 64'hFFFF_FFFF_FFFF_FFFC)
        idx = i;
    check("wr_deliv", 64'(idx >= 0), 64'd1);
    check("wr_deliv_next", got_pc[idx+1], 64'h0);
    idx = -1;
    for (int i = 0; i < acc_log.size(); i++)
      if (idx < 0 && acc_log[i] == 64'h100) idx = i;
    check("ua_addr", 64'(idx >= 0), 64'd1);
    idx = -1;
    for (int i = 0; i < acc_log.size(); i++)
      if (idx < 0 && acc_log[i] == 64'h103) idx = i;
    check("ua_no_raw", 64'(idx < 0), 64'd1);
    idx = -1;
    for (int i = 0; i < got_pc.size(); i++)
      if (idx < 0 && got_pc[i] == 64'h100) idx = i;
    check("ua_deliv", 64'(idx >= 0), 64'd1);
    check("ua_inst", 64'(got_in[idx]), 64'(wd(64'h100)));

    // asynchronous reset mid-stream
    do_reset(1);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #2;
    check("ar_req_valid", 64'(imem_req_valid), 64'd0);
    check("ar_inst_valid", 64'(inst_valid), 64'd0);
    check("ar_inst", 64'(inst), 64'd0);
    check("ar_inst_pc", inst_pc, 64'd0);
    check("ar_pc", dut.pc_q, 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #2;
    check("ar_restart_addr", imem_req_addr, 64'h0);
    repeat (10) @(negedge clk);
    check("ar_pc0", got_pc[0], 64'h0);
    check("ar_pc1", got_pc[1], 64'h4);

`ifdef FETCH_PERF_EN
    // delivered-instruction counter
    inst_ready = 1'b1;
    do_reset(1);
    #2;
    check("pf_reset", 64'(fetch_count), 64'd0);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (got_pc.size() >= 5) begin
        inst_ready = 1'b0;
        break;
      end
    end
    repeat (2) @(negedge clk);
    #2;
    check("pf_hs", 64'(got_pc.size()), 64'd5);
    check("pf_count", 64'(fetch_count), 64'd5);
    clear_count = 1'b1;
    @(negedge clk);
    clear_count = 1'b0;
    #2;
    check("pf_clear", 64'(fetch_count), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Produces the 32-bit instruction stream consumed by instruction decode, with the matching PC.
- Holds the PC register and issues in-order word requests to instruction memory.
- Buffers the returned words and presents them to decode over a valid/ready handshake.
- Accepts branch redirects from execute and flushes wrong-path instructions.

Parameters:
- ADDR_W, 64, PC/address width.
- RESET_PC, 64'h0, PC loaded on reset.
- DEPTH, 2, instruction buffer entries and the maximum number of requests in flight (power of 2, ≥2).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  ADDR_W  word address of the request; bits [1:0] are always 0.
- imem_rsp_valid  in  1  response valid; responses are in order, at least 1 cycle after acceptance.
- imem_rsp_data  in  32  instruction word.
- inst_valid  out  1  instruction available to decode.
- inst_ready  in  1  decode accepts the instruction.
- inst  out  32  instruction to decode.
- inst_pc  out  ADDR_W  PC of inst.
- redirect_valid  in  1  branch taken; single-cycle pulse.
- redirect_pc  in  ADDR_W  branch target; bits [1:0] are ignored and treated as 0.

Behaviour:
- Reset values: state=BOOT, pc=RESET_PC, rsp_pc=RESET_PC, buffer empty, out_cnt=0, drop_cnt=0, imem_req_valid=0, inst_valid=0, inst=0, inst_pc=0.
- FSM transitions:
  - BOOT→RUN after exactly one clk edge with rst_n high; no request is issued in BOOT.
  - RUN→FLUSH on a redirect while stale responses are pending (drop_cnt becomes nonzero).
  - FLUSH→RUN when drop_cnt reaches 0.
  - A redirect in FLUSH stays in FLUSH.
- Credit rule: imem_req_valid=1 in RUN or FLUSH iff out_cnt+drop_cnt+buf_cnt < DEPTH; imem_req_addr=pc.
- Request handshake (valid&&ready): pc+=4 (wraps modulo 2^ADDR_W), out_cnt+=1.
- Response handling:
  - If drop_cnt>0: decrement drop_cnt and discard the word.
  - Otherwise: push {data, rsp_pc} into the buffer, rsp_pc+=4, out_cnt-=1.
- Buffer overflow is impossible by the credit rule; a response arriving with out_cnt=0 and drop_cnt=0 is a protocol error and is ignored.
- Latency: a response pushed into an empty buffer gives inst_valid=1 on the next cycle. Throughput is 1 instruction/cycle once steady.
- Output: inst/inst_pc come from the buffer head; they pop on inst_valid&&inst_ready. inst/inst_pc hold stable while inst_valid&&!inst_ready.
- Redirect (redirect_valid=1), applied at the clock edge:
  - pc←redirect_pc, rsp_pc←redirect_pc, buffer cleared.
  - drop_cnt←drop_cnt+out_cnt, plus 1 if a request handshakes this same cycle, minus 1 if a response arrives this same cycle. The same-cycle response is discarded.
  - out_cnt←0.
  - An output handshake in the redirect cycle completes normally; decode squashes it.
  - If imem_req_valid&&!imem_req_ready during the redirect, the next cycle's request carries redirect_pc. Address change on an unaccepted request is permitted by this interface.
- Redirect and inst_ready in the same cycle: the buffer clear has priority over the pop. No entry survives.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). Responses to pre-reset requests are not expected by memory and are the integrator's responsibility.

Optional Feature:
- Macro FETCH_PERF_EN.
- When defined: adds output port fetch_count (out, 32) and input clear_count (in, 1).
  - fetch_count increments on each inst_valid&&inst_ready and wraps at 2^32.
  - It resets to 0 and also clears synchronously when clear_count=1; clear has priority over increment.
  - A fourth counter-only register is added; all other behaviour is unchanged.
- When undefined: neither port nor counter exists.

Test Plan:
- Reset release, imem_req_ready=1, 1-cycle memory, inst_ready=1 → first imem_req_addr=0x0 on the 2nd cycle after release; inst_pc sequence 0x0,0x4,0x8 at 1/cycle.
- inst_ready=0 with memory always ready → exactly DEPTH=2 requests accepted (0x0,0x4), then imem_req_valid=0. inst holds the word for 0x0 until inst_ready=1.
- 3-cycle memory latency, 2 requests outstanding, redirect_pc=0x100 → both stale responses dropped; first delivered inst_pc=0x100; FSM passes FLUSH→RUN.
- Redirect in the same cycle as a response and a request handshake → drop_cnt counts correctly; no stale instruction ever reaches decode; next inst_pc=redirect target.
- pc=0xFFFF_FFFF_FFFF_FFFC → next request address 0x0 (wrap); redirect_pc=0x103 → request address 0x100.
- rst_n pulsed low mid-stream → outputs 0 immediately; restarts at RESET_PC. With FETCH_PERF_EN: 5 handshakes → fetch_count=5; clear_count → 0.
